// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shift register.
// Words arrive on a valid/ready handshake and leave one bit per shift_en strobe.
// A one-word holding buffer lets the producer hand over the next word while the
// current one is still shifting, so consecutive words stream without a gap.
module piso_shift_reg #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hold_buf;
  logic             buf_full;

  logic             in_shift;
  logic             accept;
  logic             word_end;
  logic             buf_load;
  logic             buf_drain;

  assign in_shift = (state == ST_SHIFT);
  assign accept   = load_valid && load_ready;
  assign word_end = in_shift && shift_en && (cnt == '0);

  // The buffer only captures a word accepted mid-word; an accept that lands on
  // the end-of-word edge goes straight into the shifter instead.
  assign buf_load  = accept && in_shift && !word_end;
  assign buf_drain = word_end && buf_full;

  // Next shifter contents: move one place toward the output end, zero fill.
  always_comb begin
    shifted = shifter;
    if (MSB_FIRST) begin
      shifted = {shifter[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shifter[WIDTH-1:1]};
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign load_ready = !buf_full;
  assign sout_valid = in_shift;
  assign last_bit   = in_shift && (cnt == '0);
  assign busy       = in_shift || buf_full;
  assign sout       = in_shift ? (MSB_FIRST ? shifter[WIDTH-1] : shifter[0])
                               : IDLE_LEVEL;

  // Control FSM, shifter and bit counter; end of word prefers the buffered word,
  // then a same-edge accept, otherwise drops back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shifter <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shifter <= load_data;
            cnt     <= CNT_TOP;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (cnt != '0) begin
              shifter <= shifted;
              cnt     <= cnt - 1'b1;
            end else if (buf_full) begin
              shifter <= hold_buf;
              cnt     <= CNT_TOP;
            end else if (accept) begin
              shifter <= load_data;
              cnt     <= CNT_TOP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding buffer: filled by a mid-word accept, emptied when the shifter takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_buf <= '0;
      buf_full <= 1'b0;
    end else if (buf_drain) begin
      buf_full <= 1'b0;
    end else if (buf_load) begin
      hold_buf <= load_data;
      buf_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed scenarios for piso_shift_reg with hand-computed
// expected bit streams. Two instances cover both bit orders.
module tb_piso_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data  = 8'h00;
  logic       shift_en   = 1'b0;
  logic       sout, sout_valid, last_bit, busy;

  logic       l_load_valid = 1'b0;
  logic       l_load_ready;
  logic [7:0] l_load_data  = 8'h00;
  logic       l_shift_en   = 1'b0;
  logic       l_sout, l_sout_valid, l_last_bit, l_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .shift_en(shift_en), .sout(sout), .sout_valid(sout_valid),
    .last_bit(last_bit), .busy(busy)
  );

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .load_valid(l_load_valid), .load_ready(l_load_ready), .load_data(l_load_data),
    .shift_en(l_shift_en), .sout(l_sout), .sout_valid(l_sout_valid),
    .last_bit(l_last_bit), .busy(l_busy)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({load_ready, sout, sout_valid, last_bit, busy} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_msb got %b expected 10000",
               {load_ready, sout, sout_valid, last_bit, busy});
    end
    checks++;
    if ({l_load_ready, l_sout, l_sout_valid, l_last_bit, l_busy} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_lsb got %b expected 10000",
               {l_load_ready, l_sout, l_sout_valid, l_last_bit, l_busy});
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_seq;
    exp_seq    = 8'b0001_1110;
    load_data  = 8'h1E;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sout_valid, sout, last_bit} !== {1'b1, exp_seq[7-i], (i == 7)}) begin
        errors++;
        $display("[TB] FAIL msb_bit%0d got v/s/l=%b expected %b", i,
                 {sout_valid, sout, last_bit}, {1'b1, exp_seq[7-i], (i == 7)});
      end
      step();
    end
    checks++;
    if ({sout_valid, sout, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL msb_idle got v/s/b=%b expected 000", {sout_valid, sout, busy});
    end
    shift_en = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_seq;
    exp_seq      = 8'b0111_1000;
    l_load_data  = 8'h1E;
    l_load_valid = 1'b1;
    l_shift_en   = 1'b1;
    step();
    l_load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({l_sout_valid, l_sout, l_last_bit} !== {1'b1, exp_seq[7-i], (i == 7)}) begin
        errors++;
        $display("[TB] FAIL lsb_bit%0d got v/s/l=%b expected %b", i,
                 {l_sout_valid, l_sout, l_last_bit}, {1'b1, exp_seq[7-i], (i == 7)});
      end
      step();
    end
    checks++;
    if ({l_sout_valid, l_sout} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL lsb_idle got v/s=%b expected 00", {l_sout_valid, l_sout});
    end
    l_shift_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_seq;
    logic        exp_ready;
    exp_seq    = 16'hA50F;
    load_data  = 8'hA5;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    step();
    load_valid = 1'b0;
    load_data  = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      exp_ready = !(i >= 3 && i <= 7);
      checks++;
      if ({sout_valid, sout, last_bit, load_ready, busy} !==
          {1'b1, exp_seq[15-i], (i == 7 || i == 15), exp_ready, 1'b1}) begin
        errors++;
        $display("[TB] FAIL b2b_bit%0d got v/s/l/r/b=%b expected %b", i,
                 {sout_valid, sout, last_bit, load_ready, busy},
                 {1'b1, exp_seq[15-i], (i == 7 || i == 15), exp_ready, 1'b1});
      end
      if (i == 2) begin
        load_valid = 1'b1;
        load_data  = 8'h0F;
      end else if (i == 3) begin
        load_valid = 1'b0;
        load_data  = 8'hFF;
      end
      step();
    end
    checks++;
    if ({sout_valid, busy, load_ready} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL b2b_end got v/b/r=%b expected 001", {sout_valid, busy, load_ready});
    end
    shift_en = 1'b0;
  endtask

  task automatic test_shift_enable();
    int k;
    int j;
    load_data  = 8'h80;
    load_valid = 1'b1;
    shift_en   = 1'b0;
    step();
    load_valid = 1'b0;
    load_data  = 8'hFF;
    k = 0;
    j = 0;
    while (k < 8 && j < 40) begin
      checks++;
      if ({sout_valid, sout, last_bit} !== {1'b1, (k == 0), (k == 7)}) begin
        errors++;
        $display("[TB] FAIL gate_cyc%0d_bit%0d got v/s/l=%b expected %b", j, k,
                 {sout_valid, sout, last_bit}, {1'b1, (k == 0), (k == 7)});
      end
      shift_en = ((j % 3) == 0);
      step();
      if (shift_en) k++;
      j++;
    end
    shift_en = 1'b0;
    checks++;
    if (k != 8 || sout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gate_done got strobes=%0d valid=%b expected 8 0", k, sout_valid);
    end
    step();
  endtask

  task automatic test_reset_mid_word();
    load_data  = 8'hFF;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    step();
    load_data  = 8'h33;
    step();
    load_valid = 1'b0;
    step();
    checks++;
    if ({sout_valid, busy, load_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL rstmid_pre got v/b/r=%b expected 110", {sout_valid, busy, load_ready});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({load_ready, sout, sout_valid, last_bit, busy} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL rstmid_async got %b expected 10000",
               {load_ready, sout, sout_valid, last_bit, busy});
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({load_ready, sout, sout_valid, busy} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL rstmid_stale%0d got r/s/v/b=%b expected 1000", i,
                 {load_ready, sout, sout_valid, busy});
      end
    end
    shift_en = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] words [4];
    logic [7:0] cur;
    logic       took;
    int         w;
    words      = '{8'hC3, 8'h5A, 8'h01, 8'hFE};
    shift_en   = 1'b1;
    load_data  = words[0];
    load_valid = 1'b1;
    step();
    w = 1;
    load_data = words[1];
    for (int i = 0; i < 32; i++) begin
      cur = words[i / 8];
      checks++;
      if ({sout_valid, sout, last_bit, busy} !==
          {1'b1, cur[7 - (i % 8)], ((i % 8) == 7), 1'b1}) begin
        errors++;
        $display("[TB] FAIL stream_bit%0d got v/s/l/b=%b expected %b", i,
                 {sout_valid, sout, last_bit, busy},
                 {1'b1, cur[7 - (i % 8)], ((i % 8) == 7), 1'b1});
      end
      took = load_valid && load_ready;
      step();
      if (took) begin
        w++;
        if (w < 4) load_data = words[w];
        else load_valid = 1'b0;
      end
    end
    checks++;
    if (w != 4 || sout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_end got accepts=%0d v=%b b=%b expected 4 0 0",
               w, sout_valid, busy);
    end
    load_valid = 1'b0;
    shift_en   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_shift_enable();
    test_reset_mid_word();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
